// File: rtl/operand_collector.sv
// Operand collector: accepts one decoded instruction, reads up to two source
// registers over a single-port request/response RF interface, optionally swaps
// in an immediate for op2, then writes the operand set into the one-deep
// operand buffer when it can accept.
module operand_collector #(
  parameter int unsigned W      = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [5:0]        opcode_in,
  input  logic              is_fp_in,
  input  logic [REG_AW-1:0] src1_in,
  input  logic [REG_AW-1:0] src2_in,
  input  logic              use_imm_in,
  input  logic [W-1:0]      imm_in,
  output logic              rf_req_valid,
  output logic [REG_AW-1:0] rf_req_addr,
  input  logic              rf_req_ready,
  input  logic              rf_resp_valid,
  input  logic [W-1:0]      rf_resp_data,
  input  logic              buf_valid,
  input  logic              buf_consume,
  output logic              write_en,
  output logic [W-1:0]      op1_out,
  output logic [W-1:0]      op2_out,
  output logic [5:0]        opcode_out,
  output logic              is_fp_out,
  output logic              busy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [2:0] {
    StIdle,
    StReq1,
    StWait1,
    StReq2,
    StWait2,
    StWrite
  } state_e;

  state_e state_q, state_d;

  logic [REG_AW-1:0] src1_q, src2_q;
  logic              use_imm_q;
  logic [W-1:0]      imm_q;
  logic [W-1:0]      op1_q, op2_q;
  logic [5:0]        opcode_q;
  logic              is_fp_q;
  logic [CNT_W-1:0]  stall_q;

  logic accept;
  logic cap_op1;
  logic cap_op2_resp;
  logic cap_op2_imm;
  logic stall_inc;
  logic can_write;

  // The buffer frees its slot in the same cycle it is consumed.
  assign can_write = !buf_valid || buf_consume;

  // Next-state decode plus handshake strobes and datapath capture enables
  always_comb begin
    state_d      = state_q;
    instr_ready  = 1'b0;
    rf_req_valid = 1'b0;
    rf_req_addr  = src1_q;
    write_en     = 1'b0;
    accept       = 1'b0;
    cap_op1      = 1'b0;
    cap_op2_resp = 1'b0;
    cap_op2_imm  = 1'b0;
    stall_inc    = 1'b0;
    unique case (state_q)
      StIdle: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          accept  = 1'b1;
          state_d = StReq1;
        end
      end
      StReq1: begin
        rf_req_valid = 1'b1;
        if (rf_req_ready) state_d = StWait1;
      end
      StWait1: begin
        if (rf_resp_valid) begin
          cap_op1 = 1'b1;
          if (use_imm_q) begin
            cap_op2_imm = 1'b1;
            state_d     = StWrite;
          end else if (src1_q == src2_q) begin
            // Same register twice: reuse the first read.
            cap_op2_resp = 1'b1;
            state_d      = StWrite;
          end else begin
            state_d = StReq2;
          end
        end
      end
      StReq2: begin
        rf_req_valid = 1'b1;
        rf_req_addr  = src2_q;
        if (rf_req_ready) state_d = StWait2;
      end
      StWait2: begin
        if (rf_resp_valid) begin
          cap_op2_resp = 1'b1;
          state_d      = StWrite;
        end
      end
      StWrite: begin
        if (can_write) begin
          write_en = 1'b1;
          state_d  = StIdle;
        end else begin
          stall_inc = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Instruction latch, operand capture and saturating stall counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src1_q    <= '0;
      src2_q    <= '0;
      use_imm_q <= 1'b0;
      imm_q     <= '0;
      opcode_q  <= '0;
      is_fp_q   <= 1'b0;
      op1_q     <= '0;
      op2_q     <= '0;
      stall_q   <= '0;
    end else begin
      if (accept) begin
        src1_q    <= src1_in;
        src2_q    <= src2_in;
        use_imm_q <= use_imm_in;
        imm_q     <= imm_in;
        opcode_q  <= opcode_in;
        is_fp_q   <= is_fp_in;
      end
      if (cap_op1) op1_q <= rf_resp_data;
      if (cap_op2_imm) op2_q <= imm_q;
      else if (cap_op2_resp) op2_q <= rf_resp_data;
      if (stall_inc && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign busy       = (state_q != StIdle);
  assign op1_out    = op1_q;
  assign op2_out    = op2_q;
  assign opcode_out = opcode_q;
  assign is_fp_out  = is_fp_q;
  assign stall_cnt  = stall_q;

endmodule

// File: tb/tb_operand_collector.sv
// Bench for operand_collector: behavioural RF responder, a write monitor and a
// transaction-level reference model (expected operands, request addresses,
// write cycle and cumulative stall count).
module tb_operand_collector;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [5:0]  opcode_in = '0;
  logic        is_fp_in = 1'b0;
  logic [4:0]  src1_in = '0;
  logic [4:0]  src2_in = '0;
  logic        use_imm_in = 1'b0;
  logic [31:0] imm_in = '0;
  logic        rf_req_valid;
  logic [4:0]  rf_req_addr;
  logic        rf_req_ready = 1'b0;
  logic        rf_resp_valid = 1'b0;
  logic [31:0] rf_resp_data = '0;
  logic        buf_valid = 1'b0;
  logic        buf_consume = 1'b0;
  logic        write_en;
  logic [31:0] op1_out, op2_out;
  logic [5:0]  opcode_out;
  logic        is_fp_out;
  logic        busy;
  logic [15:0] stall_cnt;

  operand_collector dut (
    .clk          (clk),
    .rst          (rst),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .opcode_in    (opcode_in),
    .is_fp_in     (is_fp_in),
    .src1_in      (src1_in),
    .src2_in      (src2_in),
    .use_imm_in   (use_imm_in),
    .imm_in       (imm_in),
    .rf_req_valid (rf_req_valid),
    .rf_req_addr  (rf_req_addr),
    .rf_req_ready (rf_req_ready),
    .rf_resp_valid(rf_resp_valid),
    .rf_resp_data (rf_resp_data),
    .buf_valid    (buf_valid),
    .buf_consume  (buf_consume),
    .write_en     (write_en),
    .op1_out      (op1_out),
    .op2_out      (op2_out),
    .opcode_out   (opcode_out),
    .is_fp_out    (is_fp_out),
    .busy         (busy),
    .stall_cnt    (stall_cnt)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    int          wcyc;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [5:0]  opc;
    logic        fp;
  } wr_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] rf_mem [32];
  bit          can_hist [8192];
  wr_t         wr_q [$];
  logic [4:0]  req_log [$];
  int          resp_log [$];
  int          acc_cyc = 0;
  bit          addr_unstable = 1'b0;
  int          req_delay = 0;
  int          resp_delay = 0;
  bit          spur_en = 1'b0;
  int          buf_mode = 0;  // 0: buffer empty, 1: random, 2: driven by main sequence
  int          stall_exp = 0;

  logic [5:0]  e_op;
  logic        e_fp;
  logic [4:0]  e_s1, e_s2;
  logic        e_ui;
  logic [31:0] e_imm;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Register file model: optional ready delay, response latency and junk
  // response strobes whenever no read is outstanding.
  initial begin
    bit         pend = 1'b0;
    int         pend_cnt = 0;
    logic [4:0] pend_addr = '0;
    int         ready_cnt = 0;
    bit         hold_valid = 1'b0;
    logic [4:0] hold_addr = '0;
    forever begin
      @(negedge clk);
      rf_req_ready  = 1'b0;
      rf_resp_valid = 1'b0;
      rf_resp_data  = $urandom;
      if (buf_mode == 1) begin
        buf_valid   = 1'($urandom_range(0, 1));
        buf_consume = buf_valid & ($urandom_range(0, 3) == 0);
      end else if (buf_mode == 0) begin
        buf_valid   = 1'b0;
        buf_consume = 1'b0;
      end
      if (rst) begin
        pend       = 1'b0;
        ready_cnt  = 0;
        hold_valid = 1'b0;
      end else if (pend) begin
        if (pend_cnt == 0) begin
          rf_resp_valid = 1'b1;
          rf_resp_data  = rf_mem[pend_addr];
          pend          = 1'b0;
          resp_log.push_back(cyc);
        end else begin
          pend_cnt--;
        end
      end else begin
        if (spur_en) rf_resp_valid = 1'b1;
        if (rf_req_valid) begin
          if (hold_valid && (rf_req_addr !== hold_addr)) addr_unstable = 1'b1;
          if (ready_cnt >= req_delay) begin
            rf_req_ready = 1'b1;
            pend         = 1'b1;
            pend_cnt     = resp_delay;
            pend_addr    = rf_req_addr;
            req_log.push_back(rf_req_addr);
            ready_cnt    = 0;
            hold_valid   = 1'b0;
          end else begin
            ready_cnt++;
            hold_valid = 1'b1;
            hold_addr  = rf_req_addr;
          end
        end
      end
    end
  end

  // Monitor: samples late in each cycle, after all inputs have settled.
  initial forever begin
    @(negedge clk);
    #3;
    if (cyc < 8192) can_hist[cyc] = !buf_valid || buf_consume;
    if (instr_valid && instr_ready) acc_cyc = cyc;
    if (write_en) wr_q.push_back('{cyc, op1_out, op2_out, opcode_out, is_fp_out});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t required below 500000", $time);
    $fatal(1);
  end

  task automatic issue(input logic [5:0] op, input logic fp, input logic [4:0] s1,
                       input logic [4:0] s2, input logic ui, input logic [31:0] imm);
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (instr_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("instr_ready_seen", 64'(ok), 64'd1);
    e_op = op; e_fp = fp; e_s1 = s1; e_s2 = s2; e_ui = ui; e_imm = imm;
    req_log.delete();
    resp_log.delete();
    addr_unstable = 1'b0;
    instr_valid = 1'b1;
    opcode_in   = op;
    is_fp_in    = fp;
    src1_in     = s1;
    src2_in     = s2;
    use_imm_in  = ui;
    imm_in      = imm;
    @(negedge clk);
    // Scramble the inputs so only the latched copy can be used.
    instr_valid = 1'b0;
    opcode_in   = 6'($urandom);
    is_fp_in    = 1'($urandom);
    src1_in     = 5'($urandom);
    src2_in     = 5'($urandom);
    use_imm_in  = 1'($urandom);
    imm_in      = $urandom;
  endtask

  task automatic finish_instr(input int exp_lat);
    wr_t         w;
    int          enter;
    int          exp_wc;
    int          nreq;
    logic [31:0] exp_op2;
    for (int i = 0; i < 300; i++) begin
      if (wr_q.size() > 0) break;
      @(negedge clk);
      #4;
    end
    chk("write_seen", 64'(wr_q.size() > 0), 64'd1);
    if (wr_q.size() == 0) return;
    w       = wr_q[0];
    exp_op2 = e_ui ? e_imm : rf_mem[e_s2];
    chk("op1", w.op1, rf_mem[e_s1]);
    chk("op2", w.op2, exp_op2);
    chk("opcode", w.opc, e_op);
    chk("is_fp", w.fp, e_fp);
    nreq = (e_ui || (e_s1 == e_s2)) ? 1 : 2;
    chk("req_count", req_log.size(), nreq);
    if (req_log.size() > 0) chk("req_addr1", req_log[0], e_s1);
    if (nreq == 2 && req_log.size() > 1) chk("req_addr2", req_log[1], e_s2);
    chk("addr_stable", 64'(addr_unstable), 64'd0);
    if (resp_log.size() > 0) begin
      enter  = resp_log[resp_log.size() - 1] + 1;
      exp_wc = enter;
      while (exp_wc < enter + 300 && exp_wc < 8191 && !can_hist[exp_wc]) exp_wc++;
      chk("write_cycle", w.wcyc, exp_wc);
      stall_exp += exp_wc - enter;
      if (stall_exp > 65535) stall_exp = 65535;
    end
    if (exp_lat >= 0) chk("latency", w.wcyc - acc_cyc, exp_lat);
    @(negedge clk);
    #4;
    chk("single_write", wr_q.size(), 1);
    chk("idle_after_write", {busy, instr_ready}, 2'b01);
    chk("stall_cnt", stall_cnt, stall_exp);
    chk("op1_held", op1_out, w.op1);
    wr_q.delete();
  endtask

  initial begin
    int          r;
    logic [4:0]  s1, s2;
    for (int i = 0; i < 32; i++) rf_mem[i] = $urandom;

    // Reset values
    repeat (3) @(negedge clk);
    #4;
    chk("rst_instr_ready", instr_ready, 1'b1);
    chk("rst_req_valid", rf_req_valid, 1'b0);
    chk("rst_write_en", write_en, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_payload", {op1_out, op2_out, opcode_out, is_fp_out}, 64'd0);
    chk("rst_stall", stall_cnt, 16'd0);
    @(negedge clk);
    #2 rst = 1'b0;

    // Two-read path, minimum latency
    rf_mem[3] = 32'h1111_1111;
    rf_mem[7] = 32'h2222_2222;
    issue(6'h05, 1'b0, 5'd3, 5'd7, 1'b0, 32'h0);
    finish_instr(5);

    // Immediate substitution
    rf_mem[2] = 32'h0000_0005;
    issue(6'h12, 1'b0, 5'd2, 5'd30, 1'b1, 32'hDEAD_BEEF);
    finish_instr(3);

    // Same source register
    rf_mem[9] = 32'hA5A5_A5A5;
    issue(6'h21, 1'b1, 5'd9, 5'd9, 1'b0, 32'h0);
    finish_instr(3);

    // Backpressure: 4 blocked cycles, then consume on the 5th
    buf_mode    = 2;
    buf_valid   = 1'b1;
    buf_consume = 1'b0;
    rf_mem[14]  = 32'h0BAD_F00D;
    issue(6'h07, 1'b0, 5'd14, 5'd1, 1'b1, 32'h1234_5678);
    for (int i = 0; i < 100; i++) begin
      if (resp_log.size() > 0) break;
      @(negedge clk);
      #4;
    end
    chk("bp_resp_seen", resp_log.size(), 1);
    r = (resp_log.size() > 0) ? resp_log[0] : cyc;
    while (cyc < r + 4) begin
      @(negedge clk);
      #4;
    end
    chk("bp_no_write", {write_en, busy}, 2'b01);
    chk("bp_stall3", stall_cnt, 16'(stall_exp + 3));
    @(negedge clk);
    buf_consume = 1'b1;
    #4;
    chk("bp_write_now", write_en, 1'b1);
    chk("bp_stall4", stall_cnt, 16'(stall_exp + 4));
    finish_instr(-1);
    buf_mode = 0;

    // Slow RF with junk response strobes outside the read window
    req_delay  = 3;
    resp_delay = 2;
    spur_en    = 1'b1;
    rf_mem[12] = 32'hCAFE_0012;
    rf_mem[20] = 32'hBEEF_0020;
    issue(6'h33, 1'b1, 5'd12, 5'd20, 1'b0, 32'h0);
    finish_instr(15);
    req_delay  = 0;
    resp_delay = 0;
    spur_en    = 1'b0;

    // Reset while waiting for the second read
    resp_delay = 5;
    issue(6'h3F, 1'b1, 5'd4, 5'd6, 1'b0, 32'h0);
    for (int i = 0; i < 100; i++) begin
      if (req_log.size() >= 2) break;
      @(negedge clk);
      #4;
    end
    chk("rst_mid_two_reqs", req_log.size(), 2);
    @(negedge clk);
    #1;
    chk("rst_mid_busy_before", busy, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_state", {busy, instr_ready, rf_req_valid, write_en}, 4'b0100);
    chk("rst_mid_payload", {op1_out, op2_out, opcode_out, is_fp_out}, 64'd0);
    chk("rst_mid_stall", stall_cnt, 16'd0);
    stall_exp = 0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    resp_delay = 0;
    repeat (6) @(negedge clk);
    #4;
    chk("rst_mid_no_write", wr_q.size(), 0);
    rf_mem[4] = 32'h4444_0004;
    issue(6'h01, 1'b0, 5'd4, 5'd6, 1'b0, 32'h0);
    finish_instr(5);

    // Randomised traffic against the reference model
    for (int n = 0; n < 40; n++) begin
      req_delay  = $urandom_range(0, 2);
      resp_delay = $urandom_range(0, 2);
      spur_en    = 1'($urandom_range(0, 1));
      buf_mode   = 1;
      rf_mem[$urandom_range(0, 31)] = $urandom;
      s1 = 5'($urandom_range(0, 31));
      s2 = ($urandom_range(0, 4) == 0) ? s1 : 5'($urandom_range(0, 31));
      issue(6'($urandom), 1'($urandom), s1, s2, ($urandom_range(0, 3) == 0), $urandom);
      finish_instr(-1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/operand_collector.md
Name: operand_collector

Overview:
- Producer side of the SM core's one-deep operand buffer.
- Accepts a decoded instruction, reads up to two source registers through a single-port request/response register-file interface, and optionally substitutes an immediate for op2.
- Drives write_en plus payload into the operand buffer only when the buffer can accept.
- Sits between warp issue and the operand buffer feeding the ALU/FPU.

Parameters:
- W, 32, operand data width
- REG_AW, 5, register index width
- CNT_W, 16, stall counter width

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- instr_valid  input  1  issue offers an instruction
- instr_ready  output  1  collector can accept (IDLE only)
- opcode_in  input  6  opcode
- is_fp_in  input  1  floating-point flag
- src1_in  input  REG_AW  source register 1 index
- src2_in  input  REG_AW  source register 2 index
- use_imm_in  input  1  op2 comes from imm_in, not the RF
- imm_in  input  W  immediate value
- rf_req_valid  output  1  RF read request
- rf_req_addr  output  REG_AW  RF read index
- rf_req_ready  input  1  RF accepts request
- rf_resp_valid  input  1  RF read data valid
- rf_resp_data  input  W  RF read data
- buf_valid  input  1  operand buffer currently holds an entry
- buf_consume  input  1  operand buffer entry consumed this cycle
- write_en  output  1  single-cycle write pulse to operand buffer
- op1_out  output  W  operand 1 to buffer
- op2_out  output  W  operand 2 to buffer
- opcode_out  output  6  opcode to buffer
- is_fp_out  output  1  fp flag to buffer
- busy  output  1  state != IDLE
- stall_cnt  output  CNT_W  saturating count of cycles blocked in WRITE

Behaviour:
- Reset (async, immediate): state=IDLE; rf_req_valid=0, write_en=0, busy=0, instr_ready=1 (IDLE); op1_out/op2_out/opcode_out/is_fp_out=0; stall_cnt=0; latched src indices/flags=0.
- Reset mid-operation drops the in-flight instruction. Nothing is written to the buffer.
- States: IDLE, REQ1, WAIT1, REQ2, WAIT2, WRITE.
- IDLE:
  - instr_ready=1.
  - On instr_valid, latch opcode/is_fp/src1/src2/use_imm/imm and go to REQ1.
- REQ1:
  - rf_req_valid=1, rf_req_addr=src1, held stable until rf_req_ready.
  - On rf_req_ready, go to WAIT1.
- WAIT1:
  - Wait for rf_resp_valid, then capture op1_out=rf_resp_data.
  - Next state, by priority:
    - use_imm: op2_out=imm, go to WRITE.
    - src1==src2: op2_out=rf_resp_data, go to WRITE (no second read).
    - otherwise: go to REQ2.
- REQ2: as REQ1 with addr=src2; on rf_req_ready go to WAIT2.
- WAIT2: on rf_resp_valid, capture op2_out and go to WRITE.
- Responses: only sampled in WAIT1/WAIT2, earliest the cycle after the request handshake. rf_resp_valid in any other state is ignored.
- WRITE:
  - can_write = !buf_valid || buf_consume.
  - If can_write: write_en=1 for exactly one cycle, go to IDLE.
  - Otherwise: hold all outputs, increment stall_cnt (saturate at all-ones, no wrap).
  - write_en coincident with buf_consume is legal; the buffer gives write priority and stays valid with the new entry.
- Payload outputs are registered and held stable from entry to WRITE until the next instruction's capture.
- Minimum latency, 2 reads with rf_req_ready=1 and response next cycle: accept at cycle 0, write_en at cycle 5. With imm or src1==src2: write_en at cycle 3.
- Back-to-back instructions: instr_ready=0 in the write cycle; the next accept is at earliest the cycle after write_en.

Test Plan:
- Two-read path: reset; instr opcode=0x05, src1=3, src2=7, RF r3=0x11111111, r7=0x22222222, ready=1, buf_valid=0 -> addrs 3 then 7; write_en at cycle 5 with op1=0x11111111, op2=0x22222222, opcode=0x05.
- Immediate: use_imm=1, imm=0xDEADBEEF, src1=2 (r2=0x5) -> one RF request only; write_en at cycle 3, op2=0xDEADBEEF.
- Same-source: src1=src2=9, r9=0xA5A5A5A5 -> one request; op1=op2=0xA5A5A5A5.
- Backpressure: buf_valid=1, no consume, for 4 cycles in WRITE -> write_en=0, stall_cnt=4; buf_consume=1 on the 5th cycle -> write_en the same cycle; next cycle IDLE.
- Slow RF: rf_req_ready low 3 cycles, response 2 cycles late; a spurious rf_resp_valid in REQ1 -> address held stable; spurious response ignored; correct data captured.
- Reset mid-WAIT2 -> outputs zero, IDLE, no write_en; the next instruction completes normally.
